// File: rtl/difftest_batch_packer.sv
// difftest_batch_packer
// Captures wide difftest batch words from the core gateway into a small
// circular FIFO and serialises each one into fixed-width AXI-Stream beats,
// least-significant slice first. The core is never stalled: batches that
// arrive while the FIFO is full are dropped and counted.

`ifndef CONFIG_DIFFTEST_BATCH_IO_WITDH
`define CONFIG_DIFFTEST_BATCH_IO_WITDH 1000
`endif

module difftest_batch_packer #(
  parameter int IN_W  = `CONFIG_DIFFTEST_BATCH_IO_WITDH,
  parameter int OUT_W = 512,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              drop_count,
  output logic [31:0]              sent_count,
  output logic                     overflow
);

  localparam int BEATS = (IN_W + OUT_W - 1) / OUT_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PADW  = BEATS * OUT_W;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [PW:0]    FULL_LVL  = (PW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [IN_W-1:0] mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [BCW-1:0]  beat_cnt;
  logic [PADW-1:0] head_pad;
  logic            full;
  logic            fire;
  logic            last_fire;
  logic            push;
  logic            drop;

  // Occupancy and the push/drop decision; a final-beat handshake frees a slot
  // in the same cycle, so a push that coincides with it is still accepted.
  always_comb begin
    fifo_level = wr_ptr - rd_ptr;
    full       = (fifo_level == FULL_LVL);
    fire       = out_valid & out_ready;
    last_fire  = fire & out_last;
    push       = in_enable & (~full | last_fire);
    drop       = in_enable & full & ~last_fire;
  end

  // Serialiser state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Go to SEND on any push, back to IDLE when the last entry leaves with nothing arriving.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (push) next_state = SEND;
      SEND: if (last_fire && !push && fifo_level == (PW + 1)'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stream outputs; the head word is zero-extended so the final slice is padded.
  always_comb begin
    head_pad            = '0;
    head_pad[IN_W-1:0]  = mem[rd_ptr[PW-1:0]];
    out_valid           = (state == SEND);
    out_last            = out_valid && (beat_cnt == LAST_BEAT);
    out_data            = '0;
    if (out_valid) out_data = head_pad[int'(beat_cnt) * OUT_W +: OUT_W];
  end

  // FIFO storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr[PW-1:0]] <= in_data;
  end

  // Pointers, beat index and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat_cnt   <= '0;
      drop_count <= '0;
      sent_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW + 1)'(1);
      if (fire) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt   <= '0;
          rd_ptr     <= rd_ptr + (PW + 1)'(1);
          sent_count <= sent_count + 32'd1;
        end else begin
          beat_cnt <= beat_cnt + BCW'(1);
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_difftest_batch_packer.sv
// Testbench for difftest_batch_packer with IN_W=1000, OUT_W=256, DEPTH=4
// (four beats per batch, last beat carries 24 padding bits).

module tb_difftest_batch_packer;

  localparam int IN_W  = 1000;
  localparam int OUT_W = 256;
  localparam int DEPTH = 4;

  logic              clock;
  logic              reset;
  logic [IN_W-1:0]   in_data;
  logic              in_enable;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic [2:0]        fifo_level;
  logic [31:0]       drop_count;
  logic [31:0]       sent_count;
  logic              overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic push;
    logic ready;
    logic exp_valid;
    logic exp_last;
    int   exp_beat;
    int   exp_sent;
  } vec_t;

  vec_t vecs [18];

  difftest_batch_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_enable  (in_enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .sent_count (sent_count),
    .overflow   (overflow)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [IN_W-1:0] make_word(input int seed);
    logic [IN_W-1:0] w;
    w = '0;
    for (int i = 0; i < IN_W / 8; i++) w[i*8 +: 8] = 8'(i + seed);
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] beat_slice(input logic [IN_W-1:0] w, input int k);
    logic [4*OUT_W-1:0] p;
    p = {24'b0, w};
    return p[k*OUT_W +: OUT_W];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One table step: drive inputs, compare outputs, advance a cycle.
  task automatic apply_stimulus(input vec_t v, input logic [IN_W-1:0] w, inout int hs);
    in_enable = v.push;
    in_data   = w;
    out_ready = v.ready;
    check_output("tbl_valid", out_valid, v.exp_valid);
    check_output("tbl_last", out_last, v.exp_last);
    check_output("tbl_data", out_data, v.exp_valid ? beat_slice(w, v.exp_beat) : '0);
    check_output("tbl_sent", sent_count, v.exp_sent);
    if (v.exp_last) check_output("tbl_pad", out_data[255:232], 24'd0);
    if (out_valid && out_ready) hs++;
    tick();
  endtask

  // Collect one full batch with out_ready high; optionally push a new word
  // in the same cycle as the final-beat handshake.
  task automatic receive_batch(input string tag, input logic [IN_W-1:0] exp_word,
                               input bit push_on_last, input logic [IN_W-1:0] push_word);
    logic [4*OUT_W-1:0] asm_word;
    int beat;
    int cycles;
    asm_word  = '0;
    beat      = 0;
    cycles    = 0;
    out_ready = 1'b1;
    while (beat < 4 && cycles < 50) begin
      in_enable = 1'b0;
      if (out_valid) begin
        if (push_on_last && out_last) begin
          in_enable = 1'b1;
          in_data   = push_word;
        end
        check_output({tag, "_last"}, out_last, beat == 3);
        asm_word[beat*OUT_W +: OUT_W] = out_data;
        beat++;
      end
      tick();
      cycles++;
    end
    in_enable = 1'b0;
    out_ready = 1'b0;
    check_output({tag, "_beats"}, beat, 4);
    check_output({tag, "_word"}, asm_word, {24'b0, exp_word});
  endtask

  initial begin
    logic [IN_W-1:0] w;
    logic [4*OUT_W-1:0] asm_word;
    int hs;
    int pushed;
    int received;
    int beat;

    reset     = 1'b1;
    in_enable = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state, observed while reset is still asserted.
    tick();
    check_output("rst_valid", out_valid, 1'b0);
    check_output("rst_last", out_last, 1'b0);
    check_output("rst_level", fifo_level, 3'd0);
    check_output("rst_drop", drop_count, 32'd0);
    check_output("rst_sent", sent_count, 32'd0);
    check_output("rst_ovf", overflow, 1'b0);
    check_output("rst_data", out_data, '0);
    reset = 1'b0;

    // Single batch at full rate, then the same word with a stalling sink.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 1};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2};

    w  = make_word(0);
    hs = 0;
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], w, hs);
    check_output("nostall_hs", hs, 4);
    hs = 0;
    for (int i = 6; i < 18; i++) apply_stimulus(vecs[i], w, hs);
    check_output("stall_hs", hs, 4);
    in_enable = 1'b0;
    out_ready = 1'b0;

    // Overflow: six pulses into a four-entry FIFO with the sink stalled.
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      in_enable = 1'b1;
      in_data   = make_word(10 + k);
      tick();
    end
    in_enable = 1'b0;
    check_output("ovf_level", fifo_level, 3'd4);
    check_output("ovf_drop", drop_count, 32'd2);
    check_output("ovf_flag", overflow, 1'b1);

    // Full FIFO: a push landing on the final-beat handshake reuses the slot.
    receive_batch("ovf_w0", make_word(10), 1'b1, make_word(20));
    check_output("swap_level", fifo_level, 3'd4);
    check_output("swap_drop", drop_count, 32'd2);
    receive_batch("ovf_w1", make_word(11), 1'b0, '0);
    receive_batch("ovf_w2", make_word(12), 1'b0, '0);
    receive_batch("ovf_w3", make_word(13), 1'b0, '0);
    check_output("ovf_sent", sent_count, 32'd4);
    receive_batch("swap_w", make_word(20), 1'b0, '0);
    check_output("swap_sent", sent_count, 32'd5);
    check_output("swap_empty", fifo_level, 3'd0);
    check_output("ovf_sticky", overflow, 1'b1);

    // Pointer wrap: 20 batches, a push every fourth cycle, sink always ready.
    apply_reset();
    pushed   = 0;
    received = 0;
    beat     = 0;
    asm_word = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && received < 20; c++) begin
      in_enable = 1'b0;
      if (c % 4 == 0 && pushed < 20) begin
        in_enable = 1'b1;
        in_data   = make_word(100 + pushed);
        pushed++;
      end
      if (out_valid) begin
        asm_word[beat*OUT_W +: OUT_W] = out_data;
        if (out_last) begin
          check_output("wrap_beats", beat, 3);
          check_output("wrap_word", asm_word, {24'b0, make_word(100 + received)});
          received++;
          beat = 0;
        end else begin
          beat++;
        end
      end
      tick();
    end
    in_enable = 1'b0;
    check_output("wrap_count", received, 20);
    check_output("wrap_sent", sent_count, 32'd20);
    check_output("wrap_drop", drop_count, 32'd0);
    check_output("wrap_level", fifo_level, 3'd0);

    // Mid-batch reset after beat 1; the in_enable during reset is ignored.
    in_enable = 1'b1;
    in_data   = make_word(30);
    out_ready = 1'b1;
    tick();
    in_enable = 1'b0;
    check_output("mid_b0", out_data, beat_slice(make_word(30), 0));
    tick();
    check_output("mid_b1", out_data, beat_slice(make_word(30), 1));
    tick();
    reset     = 1'b1;
    in_enable = 1'b1;
    in_data   = make_word(31);
    tick();
    reset     = 1'b0;
    in_enable = 1'b0;
    check_output("mid_valid", out_valid, 1'b0);
    check_output("mid_last", out_last, 1'b0);
    check_output("mid_level", fifo_level, 3'd0);
    check_output("mid_sent", sent_count, 32'd0);
    check_output("mid_drop", drop_count, 32'd0);
    check_output("mid_ovf", overflow, 1'b0);
    check_output("mid_data", out_data, '0);
    tick();
    check_output("mid_idle", out_valid, 1'b0);

    in_enable = 1'b1;
    in_data   = make_word(32);
    out_ready = 1'b0;
    tick();
    in_enable = 1'b0;
    check_output("post_level", fifo_level, 3'd1);
    check_output("post_b0", out_data, beat_slice(make_word(32), 0));
    receive_batch("post_w", make_word(32), 1'b0, '0);
    check_output("post_sent", sent_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
